hazard_stall_unit: RTL

- Pipeline-control counterpart to the EX-stage operand-bypass logic in the 5-stage MIPS core.
- Bypassing resolves hazards by steering data. This block resolves the hazards that bypassing cannot. It does so by generating write-enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Covered cases: load-use, jr-in-ID dependence, taken branch, jump, and data-memory wait.
- Also maintains saturating performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_stall_unit_pkg.sv | 22 ++
 rtl/hazard_stall_unit_sat_counter.sv | 34 +++
 rtl/hazard_stall_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   state_e : controller FSM state (run vs. frozen on data memory)
//   REG_ZERO: architectural zero register, never a hazard source
//   prio_e  : which control class is active this cycle (also used by the perf/trace logger)
package hazard_stall_unit_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StFreeze = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    PrioNone,
    PrioFreeze,
    PrioFlush,
    PrioStall,
    PrioJflush
  } prio_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clk   : clock
//   reset : synchronous clear to zero (also used as a per-cycle clear by the caller)
//   inc   : add one this cycle unless already all-ones
//   count : current value
module hazard_stall_unit_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core. Handles the hazards operand
// bypassing cannot: load-use, jr reading a register still in flight, taken branch, jump and
// data-memory wait. Drives write-enables/flushes for all pipeline registers, keeps
// saturating performance counters and a sticky memory-timeout flag.
//   Inputs : ID-stage register fields and flags, EX/MEM destination info, branch outcome,
//            data-memory request/ready
//   Outputs: PC/IFID/IDEX/EXMEM/MEMWB write enables, IFID/IDEX flushes,
//            stall_cnt, flush_cnt, freeze_cnt, mem_timeout
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jr,
  input  logic             ID_Jump,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWr,
  input  logic [4:0]       IDEX_RegWrAddr,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_RegWrAddr,
  input  logic             EX_BranchTaken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Wr,
  output logic             IDEX_Flush,
  output logic             EXMEM_Wr,
  output logic             MEMWB_Wr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout
);

  localparam int unsigned     WaitW    = $clog2(MEM_TIMEOUT + 1);
  // Timeout fires on the edge where the wait counter steps to MEM_TIMEOUT.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  logic       lu, jrh, mem_wait;
  prio_e      prio;
  state_e     state_q;
  logic [WaitW-1:0] wait_cnt;
  logic       mem_timeout_q;

  assign lu = IDEX_MemRead && (IDEX_RegWrAddr != REG_ZERO) &&
              ((IDEX_RegWrAddr == IFID_Rs) || (ID_UsesRt && (IDEX_RegWrAddr == IFID_Rt)));

  // jr reads its target in ID, so any in-flight writer in EX, or a load in MEM, must drain.
  assign jrh = ID_Jr && (IFID_Rs != REG_ZERO) &&
               ((IDEX_RegWr && (IDEX_RegWrAddr == IFID_Rs)) ||
                (EXMEM_MemRead && (EXMEM_RegWrAddr == IFID_Rs)));

  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    prio = PrioNone;
    if (mem_wait) begin
      prio = PrioFreeze;
    end else if (EX_BranchTaken) begin
      prio = PrioFlush;
    end else if (lu || jrh) begin
      prio = PrioStall;
    end else if (ID_Jump) begin
      prio = PrioJflush;
    end
  end

  always_comb begin
    PC_Wr      = 1'b1;
    IFID_Wr    = 1'b1;
    IDEX_Wr    = 1'b1;
    EXMEM_Wr   = 1'b1;
    MEMWB_Wr   = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    unique case (prio)
      PrioFreeze: begin
        PC_Wr    = 1'b0;
        IFID_Wr  = 1'b0;
        IDEX_Wr  = 1'b0;
        EXMEM_Wr = 1'b0;
        MEMWB_Wr = 1'b0;
      end
      PrioFlush: begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end
      PrioStall: begin
        PC_Wr      = 1'b0;
        IFID_Wr    = 1'b0;
        IDEX_Flush = 1'b1;
      end
      PrioJflush: IFID_Flush = 1'b1;
      default: ;
    endcase
  end

  // Outputs are decoded straight from the wait term, so the state only tracks the freeze
  // episode for observability; it never gates the control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:    if (mem_wait) state_q <= StFreeze;
        StFreeze: if (dmem_ready) state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (prio == PrioStall),
    .count (stall_cnt)
  );

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((prio == PrioFlush) || (prio == PrioJflush)),
    .count (flush_cnt)
  );

  hazard_stall_unit_sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (prio == PrioFreeze),
    .count (freeze_cnt)
  );

  // Consecutive-wait counter: any non-wait cycle clears it.
  hazard_stall_unit_sat_counter #(.W(WaitW)) u_wait_cnt (
    .clk   (clk),
    .reset (reset || !mem_wait),
    .inc   (1'b1),
    .count (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout_q <= 1'b0;
    end else if (mem_wait && (wait_cnt >= WaitLast)) begin
      mem_timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;

endmodule
